// File: rtl/configure.sv
// rtl/configure.sv - shared request record and arbiter state encoding
package configure;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter_slot.sv
// rtl/memory_arbiter_slot.sv - one-entry request slot with pending and outstanding tracking
module memory_arbiter_slot
  import configure::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     valid,
  input  mem_req_t request,
  input  logic     grant,
  input  logic     done,
  output logic     pending,
  output mem_req_t slot_request
);

  logic     held;
  logic     outstanding;
  mem_req_t req_q;
  logic     accept;

  // A port whose response completes this cycle is already free for its next request.
  assign accept       = valid && !held && (!outstanding || done);
  assign pending      = held || accept;
  assign slot_request = held ? req_q : request;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held        <= 1'b0;
      outstanding <= 1'b0;
      req_q       <= '0;
    end else begin
      if (grant) begin
        held <= 1'b0;
      end else if (accept) begin
        held <= 1'b1;
      end
      if (accept) begin
        req_q <= request;
      end
      if (grant) begin
        outstanding <= 1'b1;
      end else if (done) begin
        outstanding <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin merge of instruction and data ports onto one memory port
module memory_arbiter
  import configure::*;
(
  input  logic        rst,
  input  logic        clk,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);

  arb_state_t state, state_next;
  mem_req_t   i_req, d_req, i_slot, d_slot, mem_q;
  logic       i_pending, d_pending;
  logic       grant_i, grant_d, can_grant;
  logic       last_grant;  // 0 = I, 1 = D

  assign i_req = '{imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
  assign d_req = '{dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};

  assign imemory_rdata = memory_rdata;
  assign dmemory_rdata = memory_rdata;
  assign imemory_ready = memory_ready && (state == BUSY_I);
  assign dmemory_ready = memory_ready && (state == BUSY_D);

  assign memory_instr = mem_q.instr;
  assign memory_addr  = mem_q.addr;
  assign memory_wdata = mem_q.wdata;
  assign memory_wstrb = mem_q.wstrb;

  memory_arbiter_slot u_slot_i (
    .clk          (clk),
    .rst          (rst),
    .valid        (imemory_valid),
    .request      (i_req),
    .grant        (grant_i),
    .done         (imemory_ready),
    .pending      (i_pending),
    .slot_request (i_slot)
  );

  memory_arbiter_slot u_slot_d (
    .clk          (clk),
    .rst          (rst),
    .valid        (dmemory_valid),
    .request      (d_req),
    .grant        (grant_d),
    .done         (dmemory_ready),
    .pending      (d_pending),
    .slot_request (d_slot)
  );

  // A grant is made from IDLE or on the completing cycle of the current transaction.
  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    state_next = state;
    can_grant  = (state == IDLE) || memory_ready;
    if (can_grant) begin
      if (i_pending && d_pending) begin
        if (last_grant) grant_i = 1'b1;
        else            grant_d = 1'b1;
      end else if (i_pending) begin
        grant_i = 1'b1;
      end else if (d_pending) begin
        grant_d = 1'b1;
      end
      if (grant_i)      state_next = BUSY_I;
      else if (grant_d) state_next = BUSY_D;
      else              state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant   <= 1'b0;
      memory_valid <= 1'b0;
      mem_q        <= '0;
    end else begin
      state        <= state_next;
      memory_valid <= grant_i || grant_d;
      if (grant_i || grant_d) begin
        last_grant <= grant_d;
      end
      if (grant_i) begin
        mem_q <= i_slot;
      end else if (grant_d) begin
        mem_q <= d_slot;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - directed vector bench for memory_arbiter
module tb_memory_arbiter;

  localparam logic [31:0] uart_base_addr = 32'h1000_0000;
  localparam logic [31:0] rd_key         = 32'hdead_0000;

  logic        rst, clk;
  logic        imemory_valid, imemory_instr, imemory_ready;
  logic [31:0] imemory_addr, imemory_wdata, imemory_rdata;
  logic [3:0]  imemory_wstrb;
  logic        dmemory_valid, dmemory_instr, dmemory_ready;
  logic [31:0] dmemory_addr, dmemory_wdata, dmemory_rdata;
  logic [3:0]  dmemory_wstrb;
  logic        memory_valid, memory_instr, memory_ready;
  logic [31:0] memory_addr, memory_wdata, memory_rdata;
  logic [3:0]  memory_wstrb;
  logic        model_ready, inject_ready;

  int errors = 0;
  int checks = 0;
  int pulse_count = 0;
  int b2b_count = 0;
  logic prev_mv = 1'b0;

  memory_arbiter dut (
    .rst           (rst),
    .clk           (clk),
    .imemory_valid (imemory_valid),
    .imemory_instr (imemory_instr),
    .imemory_addr  (imemory_addr),
    .imemory_wdata (imemory_wdata),
    .imemory_wstrb (imemory_wstrb),
    .imemory_rdata (imemory_rdata),
    .imemory_ready (imemory_ready),
    .dmemory_valid (dmemory_valid),
    .dmemory_instr (dmemory_instr),
    .dmemory_addr  (dmemory_addr),
    .dmemory_wdata (dmemory_wdata),
    .dmemory_wstrb (dmemory_wstrb),
    .dmemory_rdata (dmemory_rdata),
    .dmemory_ready (dmemory_ready),
    .memory_valid  (memory_valid),
    .memory_instr  (memory_instr),
    .memory_addr   (memory_addr),
    .memory_wdata  (memory_wdata),
    .memory_wstrb  (memory_wstrb),
    .memory_rdata  (memory_rdata),
    .memory_ready  (memory_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers one cycle after each request with a word derived from the address.
  initial model_ready = 1'b0;
  initial memory_rdata = '0;
  always @(posedge clk) begin
    model_ready  <= memory_valid;
    memory_rdata <= memory_addr ^ rd_key;
  end
  assign memory_ready = model_ready | inject_ready;

  always @(negedge clk) begin
    if (memory_valid) pulse_count++;
    if (memory_valid && prev_mv) b2b_count++;
    prev_mv = memory_valid;
  end

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dws;
    logic        emv;
    logic [31:0] ea;
    logic [31:0] ewd;
    logic [3:0]  ews;
    logic        ei;
    logic        eir;
    logic        edr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [31:0] ia, logic dv, logic [31:0] da,
                              logic [31:0] dwd, logic [3:0] dws, logic emv, logic [31:0] ea,
                              logic [31:0] ewd, logic [3:0] ews, logic ei, logic eir, logic edr);
    vec_t v;
    v = '{iv, ia, dv, da, dwd, dws, emv, ea, ewd, ews, ei, eir, edr};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    imemory_valid = 1'b0; imemory_instr = 1'b1; imemory_addr = '0;
    imemory_wdata = '0;   imemory_wstrb = '0;
    dmemory_valid = 1'b0; dmemory_instr = 1'b0; dmemory_addr = '0;
    dmemory_wdata = '0;   dmemory_wstrb = '0;
  endtask

  initial begin
    rst = 1'b0;
    inject_ready = 1'b0;
    idle_inputs();

    // simultaneous first requests; the following same-cycle reissue tie goes to I
    vecs.push_back(mk(1, 32'h0, 1, 32'h4000, 32'h1, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h4000, 32'h1, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h4004, 0, 0, 0, 32'h4000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h4004, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h4004, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // single fetch
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // back-to-back data stream
    vecs.push_back(mk(0, 0, 1, 32'h10, 32'hA, 4'hF, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h10, 32'hA, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h14, 32'hB, 4'hF, 0, 32'h10, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h14, 32'hB, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h18, 32'hC, 4'hF, 0, 32'h14, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h18, 32'hC, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h18, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // second valid before ready is dropped
    vecs.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h204, 0, 0, 0, 0, 1, 32'h200, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h200, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // byte write to the uart
    vecs.push_back(mk(0, 0, 1, uart_base_addr, 32'h41, 4'h1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, uart_base_addr, 32'h41, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, uart_base_addr, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_mvalid", 32'(memory_valid), 32'h0);
    check("rst_maddr", memory_addr, 32'h0);
    check("rst_mwdata", memory_wdata, 32'h0);
    check("rst_mwstrb", 32'(memory_wstrb), 32'h0);
    check("rst_minstr", 32'(memory_instr), 32'h0);
    check("rst_iready", 32'(imemory_ready), 32'h0);
    check("rst_dready", 32'(dmemory_ready), 32'h0);
    rst = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      imemory_valid = vecs[r].iv;
      imemory_addr  = vecs[r].ia;
      dmemory_valid = vecs[r].dv;
      dmemory_addr  = vecs[r].da;
      dmemory_wdata = vecs[r].dwd;
      dmemory_wstrb = vecs[r].dws;
      #1;
      check($sformatf("r%0d_mvalid", r), 32'(memory_valid), 32'(vecs[r].emv));
      check($sformatf("r%0d_iready", r), 32'(imemory_ready), 32'(vecs[r].eir));
      check($sformatf("r%0d_dready", r), 32'(dmemory_ready), 32'(vecs[r].edr));
      if (vecs[r].emv) begin
        check($sformatf("r%0d_maddr", r), memory_addr, vecs[r].ea);
        check($sformatf("r%0d_mwdata", r), memory_wdata, vecs[r].ewd);
        check($sformatf("r%0d_mwstrb", r), 32'(memory_wstrb), 32'(vecs[r].ews));
        check($sformatf("r%0d_minstr", r), 32'(memory_instr), 32'(vecs[r].ei));
      end
      if (vecs[r].eir) check($sformatf("r%0d_irdata", r), imemory_rdata, vecs[r].ea ^ rd_key);
      if (vecs[r].edr) check($sformatf("r%0d_drdata", r), dmemory_rdata, vecs[r].ea ^ rd_key);
    end

    // reset while D is outstanding
    @(negedge clk);
    dmemory_valid = 1'b1; dmemory_addr = 32'h300; dmemory_wdata = '0; dmemory_wstrb = '0;
    @(negedge clk);
    idle_inputs();
    #1;
    check("busy_d_mvalid", 32'(memory_valid), 32'h1);
    #1;
    rst = 1'b0;
    inject_ready = 1'b1;
    #1;
    check("mid_rst_mvalid", 32'(memory_valid), 32'h0);
    check("mid_rst_maddr", memory_addr, 32'h0);
    check("mid_rst_minstr", 32'(memory_instr), 32'h0);
    check("mid_rst_dready", 32'(dmemory_ready), 32'h0);
    check("mid_rst_rdata", dmemory_rdata, memory_rdata);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("stray_dready", 32'(dmemory_ready), 32'h0);
    check("stray_iready", 32'(imemory_ready), 32'h0);
    @(negedge clk);
    inject_ready = 1'b0;
    imemory_valid = 1'b1; imemory_addr = 32'h400;
    #1;
    check("post_rst_idle", 32'(memory_valid), 32'h0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("post_rst_mvalid", 32'(memory_valid), 32'h1);
    check("post_rst_maddr", memory_addr, 32'h400);
    @(negedge clk);
    #1;
    check("post_rst_iready", 32'(imemory_ready), 32'h1);
    check("post_rst_irdata", imemory_rdata, 32'h400 ^ rd_key);
    check("post_rst_dready", 32'(dmemory_ready), 32'h0);
    @(negedge clk);
    #1;
    check("pulse_count", 32'(pulse_count), 32'd11);
    check("b2b_count", 32'(b2b_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port to one-port memory arbiter placed directly upstream of the testbench/SoC memory. It merges the core's instruction-fetch port and data port onto the single `memory_*` request/response interface the memory consumes. Requests are buffered per port, granted round-robin, issued as one-cycle `memory_valid` pulses, and each response is routed back to the port that owns it.

## Interface
Parameters: none. Widths are fixed at 32-bit address/data and a 4-bit strobe.

Ports:
- `rst` in 1: asynchronous reset, active-low.
- `clk` in 1: single clock, rising edge.
- `imemory_valid` in 1: one-cycle request pulse from the instruction port.
- `imemory_instr` in 1: fetch tag, forwarded unchanged.
- `imemory_addr` in 32: byte address.
- `imemory_wdata` in 32: write data.
- `imemory_wstrb` in 4: byte enables; 0 means read.
- `imemory_rdata` out 32: read data to the instruction port.
- `imemory_ready` out 1: one-cycle completion pulse to the instruction port.
- `dmemory_valid`, `dmemory_instr`, `dmemory_addr`, `dmemory_wdata`, `dmemory_wstrb`: in, same widths and meanings for the data port.
- `dmemory_rdata`, `dmemory_ready`: out, same widths and meanings for the data port.
- `memory_valid` out 1: one-cycle request pulse to memory, registered.
- `memory_instr` out 1, `memory_addr` out 32, `memory_wdata` out 32, `memory_wstrb` out 4: registered request fields.
- `memory_rdata` in 32: read data from memory.
- `memory_ready` in 1: completion pulse from memory, one cycle after `memory_valid`.

## Operation
- **Request capture.** Each port has a one-entry slot (pending bit plus instr/addr/wdata/wstrb).
  - A port valid pulse loads its slot when that port has neither a pending nor an outstanding request.
  - Otherwise the pulse is ignored. Requesters must wait for their ready.
- **Same-cycle reissue.** A port valid in the same cycle as that port's own ready is accepted. The port counts as free at that edge.
- **State machine** (`arb_state_t`): IDLE, BUSY_I, BUSY_D.
  - IDLE: if any slot is pending or any port valid is present this cycle, grant and go to BUSY_I or BUSY_D. Drive `memory_valid`=1 with the granted fields for exactly the next cycle.
  - BUSY_x: wait for `memory_ready`. On that cycle, forward the response to port x and clear x's outstanding flag.
    - If another request is pending or arriving, grant it directly (no IDLE cycle).
    - Otherwise go to IDLE.
- **Arbitration.** Round-robin on a `last_grant` bit.
  - When both ports request, grant the port not granted last.
  - Reset value of `last_grant` is I, so the first tie goes to D.
  - A single requester is always granted.
- **Bypass.** A port valid arriving while its slot is empty and a grant is being made may be granted straight from the input. This is equivalent to a same-cycle slot load.
- **Response routing.** Combinational.
  - `imemory_rdata` = `dmemory_rdata` = `memory_rdata`.
  - `imemory_ready` = `memory_ready` & (state==BUSY_I).
  - `dmemory_ready` = `memory_ready` & (state==BUSY_D).
- **Stray ready.** A `memory_ready` seen in IDLE is discarded.

## Timing
- **Reset values:** `memory_valid`=0, `memory_instr`=0, `memory_addr`=0, `memory_wdata`=0, `memory_wstrb`=0. Both slots empty, state IDLE, `last_grant`=I.
- **Reset-dependent outputs:** `imemory_ready`=0 and `dmemory_ready`=0 while in reset. `*_rdata` follows `memory_rdata`.
- **Uncontended latency:** port valid at cycle t → `memory_valid` at t+1 → port ready at t+2.
- **Throughput:** one transaction per 2 cycles. `memory_valid` is never high in two consecutive cycles.
- **Contended latency:** the losing port's request reaches `memory_valid` two cycles after the winner's.
- **Reset mid-transaction:** asserting `rst` at any point clears slots, outstanding flags and state immediately.
  - A memory response arriving after reset release is dropped.
  - No port ready is generated for a request accepted before reset.

## Structure
- **Shared package `configure`:**
  - Add `mem_req_t` struct: instr, addr[31:0], wdata[31:0], wstrb[3:0].
  - Add enum `arb_state_t`: IDLE, BUSY_I, BUSY_D.
- **Sub-module `memory_arbiter_slot`**, instantiated twice.
  - Holds pending bit, outstanding bit and `mem_req_t`.
  - Inputs: valid, request, grant, done.
  - Outputs: pending, request.

## Test plan
- **Single fetch:** `imemory_valid` at cycle 5, addr 0x100, wstrb 0.
  - `memory_valid` at cycle 6 with addr 0x100, instr=1.
  - `imemory_ready` at cycle 7 with the word at 0x100.
  - `dmemory_ready` stays 0.
- **Simultaneous first requests:** I reads 0x0 and D writes 0x4000 with wdata 0x1, wstrb 0xF.
  - D is issued first, I one transaction later.
  - Next tie goes to I.
- **Back-to-back stream:** D writes 0x10, 0x14, 0x18, each re-issued on its ready.
  - `memory_valid` at every other cycle.
  - Addresses appear in order and no request is lost.
- **Illegal second valid:** I issues 0x200 then 0x204 before its ready.
  - Only 0x200 reaches memory.
  - Exactly one `imemory_ready`.
- **Reset during BUSY_D:** reset while D is outstanding.
  - Outputs take their reset values.
  - The subsequent `memory_ready` produces no port ready.
  - A new I request after reset completes normally.
- **UART write through D:** D writes to `uart_base_addr`, wstrb 0x1, wdata 0x41.
  - Memory sees it unchanged.
  - `dmemory_ready` arrives 2 cycles after `dmemory_valid`.
